// File: rtl/nnrv_bus.sv
// Shared-RAM bus for a fetch port and a data port, with a round-robin arbiter and a
// memory-mapped LED register. Each transaction runs IDLE -> ACCESS -> RESP.
module nnrv_bus #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned LED_WIDTH   = 4,
  parameter logic [31:0] LED_ADDR    = 32'h0000_0400
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_f_req,
  input  logic [XLEN-1:0]      i_f_addr,
  output logic                 o_f_ack,
  output logic [XLEN-1:0]      o_f_data,
  input  logic                 i_d_req,
  input  logic                 i_d_we,
  input  logic [XLEN-1:0]      i_d_addr,
  input  logic [3:0]           i_d_mask,
  input  logic                 i_d_sign,
  input  logic [XLEN-1:0]      i_d_wdata,
  output logic                 o_d_ack,
  output logic                 o_d_err,
  output logic [XLEN-1:0]      o_d_rdata,
  output logic [LED_WIDTH-1:0] o_led
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  localparam logic [2:0] WaitCnt = 3'(WAIT_STATES);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              last_data_q, last_data_d;
  logic              sel_data_q, sel_data_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic              we_q, we_d;
  logic [3:0]        mask_q, mask_d;
  logic              sign_q, sign_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              grant_data;

  logic [XLEN-1:0]   mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [1:0]        off;
  logic              is_led, size_ok, misalign, d_err, commit, ram_we, led_we;
  logic [3:0]        lanes;
  logic [XLEN-1:0]   ram_rd, rep, merged, shifted, ld_val;

  logic                 f_ack_q, d_ack_q, d_err_q;
  logic [XLEN-1:0]      f_data_q, d_rdata_q;
  logic [LED_WIDTH-1:0] led_q;

  // Arbiter and transaction sequencing.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_data_d = last_data_q;
    sel_data_d  = sel_data_q;
    addr_d      = addr_q;
    we_d        = we_q;
    mask_d      = mask_q;
    sign_d      = sign_q;
    wdata_d     = wdata_q;
    grant_data  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_f_req || i_d_req) begin
          // Data wins unless it was also the last master served.
          grant_data  = i_d_req && (!i_f_req || !last_data_q);
          sel_data_d  = grant_data;
          last_data_d = grant_data;
          addr_d      = grant_data ? i_d_addr : i_f_addr;
          we_d        = grant_data && i_d_we;
          mask_d      = i_d_mask;
          sign_d      = i_d_sign;
          wdata_d     = i_d_wdata;
          cnt_d       = '0;
          state_d     = StAccess;
        end
      end
      StAccess: begin
        if (cnt_q == WaitCnt) state_d = StResp;
        else                  cnt_d   = cnt_q + 3'd1;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Access decode from the latched request.
  always_comb begin
    word_idx = addr_q[ADDR_WIDTH+1:2];
    off      = addr_q[1:0];
    is_led   = (addr_q == XLEN'(LED_ADDR));
    size_ok  = 1'b1;
    misalign = 1'b0;
    case (mask_q)
      4'b0001: misalign = 1'b0;
      4'b0011: misalign = off[0];
      4'b1111: misalign = |off;
      default: size_ok  = 1'b0;
    endcase
    d_err  = !size_ok || misalign || (is_led && (mask_q != 4'b1111));
    commit = (state_q == StAccess) && (cnt_q == WaitCnt);
    ram_we = commit && sel_data_q && we_q && !d_err && !is_led;
    led_we = commit && sel_data_q && we_q && !d_err && is_led;
    ram_rd = mem[word_idx];

    lanes = mask_q << off;
    case (mask_q)
      4'b0001: rep = {4{wdata_q[7:0]}};
      4'b0011: rep = {2{wdata_q[15:0]}};
      default: rep = wdata_q;
    endcase
    for (int b = 0; b < 4; b++) begin
      merged[8*b +: 8] = lanes[b] ? rep[8*b +: 8] : ram_rd[8*b +: 8];
    end

    shifted = ram_rd >> {off, 3'b000};
    case (mask_q)
      4'b0001: ld_val = {{(XLEN-8){sign_q & shifted[7]}}, shifted[7:0]};
      4'b0011: ld_val = {{(XLEN-16){sign_q & shifted[15]}}, shifted[15:0]};
      default: ld_val = shifted;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      last_data_q <= 1'b0;
      sel_data_q  <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      mask_q      <= '0;
      sign_q      <= 1'b0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_data_q <= last_data_d;
      sel_data_q  <= sel_data_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      mask_q      <= mask_d;
      sign_q      <= sign_d;
      wdata_q     <= wdata_d;
    end
  end

  // RAM is not reset; a write coinciding with reset is dropped.
  always_ff @(posedge i_clk) begin
    if (!i_rst && ram_we) mem[word_idx] <= merged;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      f_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      d_err_q   <= 1'b0;
      f_data_q  <= '0;
      d_rdata_q <= '0;
      led_q     <= '0;
    end else begin
      f_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      d_err_q <= 1'b0;
      if (commit) begin
        if (sel_data_q) begin
          d_ack_q <= 1'b1;
          d_err_q <= d_err;
          if (d_err)      d_rdata_q <= '0;
          else if (!we_q) d_rdata_q <= is_led ? XLEN'(led_q) : ld_val;
        end else begin
          f_ack_q  <= 1'b1;
          f_data_q <= ram_rd;
        end
      end
      if (led_we) led_q <= wdata_q[LED_WIDTH-1:0];
    end
  end

  assign o_f_ack   = f_ack_q;
  assign o_f_data  = f_data_q;
  assign o_d_ack   = d_ack_q;
  assign o_d_err   = d_err_q;
  assign o_d_rdata = d_rdata_q;
  assign o_led     = led_q;

endmodule

// File: tb/tb_nnrv_bus.sv
// Bench for nnrv_bus: vector table, arbitration and reset sequences, and random traffic
// against a byte-level memory model.
module tb_nnrv_bus;

  localparam logic [31:0] LED = 32'h0000_0400;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst    [2];
  logic        f_req  [2];
  logic [31:0] f_addr [2];
  logic        f_ack  [2];
  logic [31:0] f_data [2];
  logic        d_req  [2];
  logic        d_we   [2];
  logic [31:0] d_addr [2];
  logic [3:0]  d_mask [2];
  logic        d_sign [2];
  logic [31:0] d_wdata[2];
  logic        d_ack  [2];
  logic        d_err  [2];
  logic [31:0] d_rdata[2];
  logic [3:0]  led    [2];

  nnrv_bus #(.WAIT_STATES(0)) dut0 (
    .i_clk(clk), .i_rst(rst[0]), .i_f_req(f_req[0]), .i_f_addr(f_addr[0]),
    .o_f_ack(f_ack[0]), .o_f_data(f_data[0]), .i_d_req(d_req[0]), .i_d_we(d_we[0]),
    .i_d_addr(d_addr[0]), .i_d_mask(d_mask[0]), .i_d_sign(d_sign[0]),
    .i_d_wdata(d_wdata[0]), .o_d_ack(d_ack[0]), .o_d_err(d_err[0]),
    .o_d_rdata(d_rdata[0]), .o_led(led[0])
  );

  nnrv_bus #(.WAIT_STATES(3)) dut3 (
    .i_clk(clk), .i_rst(rst[1]), .i_f_req(f_req[1]), .i_f_addr(f_addr[1]),
    .o_f_ack(f_ack[1]), .o_f_data(f_data[1]), .i_d_req(d_req[1]), .i_d_we(d_we[1]),
    .i_d_addr(d_addr[1]), .i_d_mask(d_mask[1]), .i_d_sign(d_sign[1]),
    .i_d_wdata(d_wdata[1]), .o_d_ack(d_ack[1]), .o_d_err(d_err[1]),
    .o_d_rdata(d_rdata[1]), .o_led(led[1])
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  // Byte-addressed reference memory (RAM aliases every 1 KiB) and LED value.
  logic [7:0] mb [1024];
  logic [3:0] m_led;

  function automatic void model(input logic we, input logic [31:0] addr, input logic [3:0] mask,
                                input logic sign, input logic [31:0] wdata,
                                output logic [31:0] rd, output logic err);
    int size;
    int base;
    logic [31:0] v;
    size = (mask == 4'h1) ? 1 : (mask == 4'h3) ? 2 : (mask == 4'hF) ? 4 : 0;
    rd  = '0;
    err = 1'b0;
    if (size == 0) err = 1'b1;
    else if ((addr % size) != 0) err = 1'b1;
    else if (addr == LED && size != 4) err = 1'b1;
    if (err) return;
    if (addr == LED) begin
      if (we) m_led = wdata[3:0];
      rd = {28'b0, m_led};
      return;
    end
    base = int'(addr % 1024);
    if (we) begin
      for (int i = 0; i < size; i++) mb[base+i] = wdata[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < size; i++) v = v | (32'(mb[base+i]) << (8*i));
      if (sign && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
      rd = v;
    end
  endfunction

  function automatic logic [31:0] mword(input logic [31:0] addr);
    int b;
    b = int'((addr % 1024) & 32'h3FC);
    return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
  endfunction

  task automatic data_op(input int k, input logic we, input logic [31:0] addr,
                         input logic [3:0] mask, input logic sign, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat);
    @(posedge clk);
    #1;
    d_we[k] = we; d_addr[k] = addr; d_mask[k] = mask; d_sign[k] = sign; d_wdata[k] = wdata;
    d_req[k] = 1'b1;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (d_ack[k]) begin
        lat = n - 1;
        break;
      end
    end
    rdata = d_rdata[k];
    err   = d_err[k];
    d_req[k] = 1'b0;
  endtask

  task automatic fetch_op(input int k, input logic [31:0] addr,
                          output logic [31:0] data, output int lat);
    @(posedge clk);
    #1;
    f_addr[k] = addr;
    f_req[k]  = 1'b1;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (f_ack[k]) begin
        lat = n - 1;
        break;
      end
    end
    data = f_data[k];
    f_req[k] = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic        sign;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  led;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [31:0] rd, exp_rd, wd, a;
    logic        er, exp_er, we, sg;
    logic [3:0]  mk;
    logic [3:0]  masks [8];
    int          lat, got, acks;
    int          seq [4];

    masks = '{4'h1, 4'h3, 4'hF, 4'hF, 4'h7, 4'h0, 4'h1, 4'h3};
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; f_req[k] = 1'b0; f_addr[k] = '0; d_req[k] = 1'b0; d_we[k] = 1'b0;
      d_addr[k] = '0; d_mask[k] = '0; d_sign[k] = 1'b0; d_wdata[k] = '0;
    end
    m_led = '0;

    tbl.push_back('{1'b1, 32'h10,  4'hF, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 4'h0});
    tbl.push_back('{1'b0, 32'h10,  4'hF, 1'b0, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 4'h0});
    tbl.push_back('{1'b1, 32'h13,  4'h1, 1'b0, 32'h80,       1'b0, 32'h0,        1'b0, 4'h0});
    tbl.push_back('{1'b0, 32'h13,  4'h1, 1'b1, 32'h0,        1'b1, 32'hFFFFFF80, 1'b0, 4'h0});
    tbl.push_back('{1'b0, 32'h13,  4'h1, 1'b0, 32'h0,        1'b1, 32'h00000080, 1'b0, 4'h0});
    tbl.push_back('{1'b0, 32'h10,  4'hF, 1'b0, 32'h0,        1'b1, 32'h80ADBEEF, 1'b0, 4'h0});
    tbl.push_back('{1'b0, 32'h11,  4'h3, 1'b0, 32'h0,        1'b1, 32'h0,        1'b1, 4'h0});
    tbl.push_back('{1'b0, 32'h10,  4'h7, 1'b0, 32'h0,        1'b1, 32'h0,        1'b1, 4'h0});
    tbl.push_back('{1'b0, 32'h10,  4'hF, 1'b0, 32'h0,        1'b1, 32'h80ADBEEF, 1'b0, 4'h0});
    tbl.push_back('{1'b1, 32'h11,  4'h3, 1'b0, 32'h1234,     1'b1, 32'h0,        1'b1, 4'h0});
    tbl.push_back('{1'b0, 32'h10,  4'hF, 1'b0, 32'h0,        1'b1, 32'h80ADBEEF, 1'b0, 4'h0});
    tbl.push_back('{1'b1, 32'h12,  4'h3, 1'b0, 32'hABCD,     1'b0, 32'h0,        1'b0, 4'h0});
    tbl.push_back('{1'b0, 32'h12,  4'h3, 1'b1, 32'h0,        1'b1, 32'hFFFFABCD, 1'b0, 4'h0});
    tbl.push_back('{1'b0, 32'h10,  4'hF, 1'b0, 32'h0,        1'b1, 32'hABCDBEEF, 1'b0, 4'h0});
    tbl.push_back('{1'b1, LED,     4'hF, 1'b0, 32'h5,        1'b0, 32'h0,        1'b0, 4'h5});
    tbl.push_back('{1'b0, LED,     4'hF, 1'b0, 32'h0,        1'b1, 32'h5,        1'b0, 4'h5});
    tbl.push_back('{1'b0, LED,     4'h1, 1'b0, 32'h0,        1'b1, 32'h0,        1'b1, 4'h5});
    tbl.push_back('{1'b0, 32'h410, 4'hF, 1'b0, 32'h0,        1'b1, 32'hABCDBEEF, 1'b0, 4'h5});
    tbl.push_back('{1'b1, 32'h11,  4'h1, 1'b0, 32'h1FF,      1'b0, 32'h0,        1'b0, 4'h5});
    tbl.push_back('{1'b0, 32'h10,  4'hF, 1'b0, 32'h0,        1'b1, 32'hABCDFFEF, 1'b0, 4'h5});
    tbl.push_back('{1'b0, 32'h10,  4'h3, 1'b0, 32'h0,        1'b1, 32'h0000FFEF, 1'b0, 4'h5});
    tbl.push_back('{1'b0, 32'h10,  4'h3, 1'b1, 32'h0,        1'b1, 32'hFFFFFFEF, 1'b0, 4'h5});
    tbl.push_back('{1'b1, 32'h12,  4'hF, 1'b0, 32'h0,        1'b1, 32'h0,        1'b1, 4'h5});

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst%0d_f_ack", k),   32'(f_ack[k]),  32'd0);
      check($sformatf("rst%0d_d_ack", k),   32'(d_ack[k]),  32'd0);
      check($sformatf("rst%0d_d_err", k),   32'(d_err[k]),  32'd0);
      check($sformatf("rst%0d_f_data", k),  f_data[k],      32'd0);
      check($sformatf("rst%0d_d_rdata", k), d_rdata[k],     32'd0);
      check($sformatf("rst%0d_led", k),     32'(led[k]),    32'd0);
    end
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    foreach (tbl[i]) begin
      data_op(0, tbl[i].we, tbl[i].addr, tbl[i].mask, tbl[i].sign, tbl[i].wdata, rd, er, lat);
      model(tbl[i].we, tbl[i].addr, tbl[i].mask, tbl[i].sign, tbl[i].wdata, exp_rd, exp_er);
      check($sformatf("tbl%0d_lat", i), 32'(lat), 32'd2);
      check($sformatf("tbl%0d_err", i), 32'(er), 32'(tbl[i].err));
      if (tbl[i].chk) check($sformatf("tbl%0d_rdata", i), rd, tbl[i].rdata);
      check($sformatf("tbl%0d_led", i), 32'(led[0]), 32'(tbl[i].led));
      @(negedge clk);
      check($sformatf("tbl%0d_ack_pulse", i), 32'(d_ack[0]), 32'd0);
      check($sformatf("tbl%0d_err_idle", i), 32'(d_err[0]), 32'd0);
    end

    fetch_op(0, 32'h12, rd, lat);
    check("fetch_offset_data", rd, 32'hABCDFFEF);
    check("fetch_offset_lat", 32'(lat), 32'd2);
    fetch_op(0, 32'h412, rd, lat);
    check("fetch_wrap_data", rd, 32'hABCDFFEF);

    for (int w = 0; w < 8; w++) begin
      wd = $urandom;
      data_op(0, 1'b1, 32'(4*w), 4'hF, 1'b0, wd, rd, er, lat);
      model(1'b1, 32'(4*w), 4'hF, 1'b0, wd, exp_rd, exp_er);
    end

    // Both masters requesting continuously: last grant was fetch, so data goes first.
    fetch_op(0, 32'h0, rd, lat);
    seq = '{-1, -1, -1, -1};
    got = 0;
    @(posedge clk);
    #1;
    f_addr[0] = 32'h10; f_req[0] = 1'b1;
    d_we[0] = 1'b0; d_addr[0] = 32'h14; d_mask[0] = 4'hF; d_sign[0] = 1'b0; d_req[0] = 1'b1;
    for (int n = 0; n < 60 && got < 4; n++) begin
      @(negedge clk);
      if (d_ack[0]) begin
        seq[got] = 1;
        check($sformatf("alt%0d_ddata", got), d_rdata[0], mword(32'h14));
        got++;
      end else if (f_ack[0]) begin
        seq[got] = 0;
        check($sformatf("alt%0d_fdata", got), f_data[0], mword(32'h10));
        got++;
      end
    end
    f_req[0] = 1'b0;
    d_req[0] = 1'b0;
    check("alt_count", 32'(got), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("alt%0d_order", i), 32'(seq[i]), 32'(i % 2 == 0));

    for (int it = 0; it < 300; it++) begin
      a = ($urandom_range(0, 3) << 10) | $urandom_range(0, 31);
      if ($urandom_range(0, 4) == 0) begin
        exp_rd = mword(a);
        fetch_op(0, a, rd, lat);
        check($sformatf("rnd%0d_fetch", it), rd, exp_rd);
        check($sformatf("rnd%0d_flat", it), 32'(lat), 32'd2);
      end else begin
        mk = masks[$urandom_range(0, 7)];
        we = 1'($urandom_range(0, 1));
        sg = 1'($urandom_range(0, 1));
        wd = $urandom;
        model(we, a, mk, sg, wd, exp_rd, exp_er);
        data_op(0, we, a, mk, sg, wd, rd, er, lat);
        check($sformatf("rnd%0d_lat", it), 32'(lat), 32'd2);
        check($sformatf("rnd%0d_err", it), 32'(er), 32'(exp_er));
        if (!we || exp_er) check($sformatf("rnd%0d_rdata", it), rd, exp_rd);
        check($sformatf("rnd%0d_led", it), 32'(led[0]), 32'(m_led));
      end
    end

    data_op(1, 1'b1, 32'h20, 4'hF, 1'b0, 32'h11111111, rd, er, lat);
    check("ws3_store_lat", 32'(lat), 32'd5);
    check("ws3_store_err", 32'(er), 32'd0);
    data_op(1, 1'b1, LED, 4'hF, 1'b0, 32'h5, rd, er, lat);
    check("ws3_led_lat", 32'(lat), 32'd5);
    check("ws3_led_val", 32'(led[1]), 32'h5);
    data_op(1, 1'b0, LED, 4'hF, 1'b0, 32'h0, rd, er, lat);
    check("ws3_led_load", rd, 32'h5);

    // Start a store, then reset while it sits in ACCESS before its commit edge.
    @(posedge clk);
    #1;
    d_we[1] = 1'b1; d_addr[1] = 32'h20; d_mask[1] = 4'hF; d_sign[1] = 1'b0;
    d_wdata[1] = 32'h22222222; d_req[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst[1]   = 1'b1;
    d_req[1] = 1'b0;
    acks = 0;
    @(negedge clk);
    if (d_ack[1] || f_ack[1]) acks++;
    @(posedge clk);
    #1;
    rst[1] = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (d_ack[1] || f_ack[1]) acks++;
    end
    check("ws3_abort_no_ack", 32'(acks), 32'd0);
    check("ws3_abort_led", 32'(led[1]), 32'd0);
    data_op(1, 1'b0, 32'h20, 4'hF, 1'b0, 32'h0, rd, er, lat);
    check("ws3_abort_ram", rd, 32'h11111111);
    check("ws3_abort_lat", 32'(lat), 32'd5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
